// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer:
//   - ALU opcode encodings (OP_PASS .. OP_INC) and the last legal opcode
//   - FSM state encoding for the sequencer
//   - ALU pipeline latencies (result after 1 edge, zero flag after 2 edges)
//   - is_legal_op(): true for opcodes 0000..0110
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHL1 = 4'b0011;
  localparam logic [3:0] OP_SHL2 = 4'b0100;
  localparam logic [3:0] OP_SHR4 = 4'b0101;
  localparam logic [3:0] OP_INC  = 4'b0110;
  localparam logic [3:0] OP_LAST = 4'b0110;

  // Edges from the ALU sampling its inputs to each output being valid.
  localparam int ALU_OUT_LAT = 1;
  localparam int ALU_Z_LAT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXEC   = 3'd1,
    ST_WAIT_Z = 3'd2,
    ST_CAPT   = 3'd3,
    ST_DONE   = 3'd4
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_ref_model.sv
// -----------------------------------------------------------------------------
// alu_ref_model
// Combinational model of the ALU opcode table, used by the sequencer's
// optional self-check to predict what the real ALU should return.
// Ports:
//   op     : opcode (OPW bits)
//   a, b   : operands (DWIDTH bits)
//   result : expected ALU output; 0 for any illegal opcode. Wraps mod 2^DWIDTH.
// -----------------------------------------------------------------------------
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int OPW    = 4
) (
  input  logic [OPW-1:0]    op,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] result
);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves it unassigned and no latch is inferred.
    result = '0;
    case (op)
      OP_PASS: result = a;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SHL1: result = a << 1;
      OP_SHL2: result = a << 2;
      OP_SHR4: result = a >> 4;
      OP_INC:  result = a + DWIDTH'(1);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Accepts one ALU command per cmd valid/ready handshake, holds it on the ALU
// inputs while the registered ALU computes, captures result and zero flag,
// and returns them on a rsp valid/ready channel.
//   accept (E0) -> EXEC (ALU samples, E1) -> WAIT_Z (Z updates, E2)
//   -> CAPT (response registered, E3) -> DONE (wait for rsp_ready)
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_valid/ready/op/a/b   : command channel (ready only in IDLE)
//   alu_operation/operand1/2 : registered drive to the ALU, stable until the
//                              next accept
//   alu_out, alu_z           : ALU result and zero flag
//   rsp_valid/ready/data/zero/err : response channel; err marks an opcode
//                              outside 0000..0110
// Build option: define ALU_SEQ_SELFCHECK_EN to add a reference model and a
// sticky selfcheck_fail output that flags ALU results disagreeing with it.
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int OPW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OPW-1:0]    cmd_op,
  input  logic [DWIDTH-1:0] cmd_a,
  input  logic [DWIDTH-1:0] cmd_b,
  output logic [OPW-1:0]    alu_operation,
  output logic [DWIDTH-1:0] alu_operand1,
  output logic [DWIDTH-1:0] alu_operand2,
  input  logic [DWIDTH-1:0] alu_out,
  input  logic              alu_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_zero,
  output logic              rsp_err
`ifdef ALU_SEQ_SELFCHECK_EN
  ,
  output logic              selfcheck_fail
`endif
);

  seq_state_e        state_q,     state_d;
  logic [OPW-1:0]    alu_op_q,    alu_op_d;
  logic [DWIDTH-1:0] alu_a_q,     alu_a_d;
  logic [DWIDTH-1:0] alu_b_q,     alu_b_d;
  logic              illegal_q,   illegal_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DWIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_zero_q,  rsp_zero_d;
  logic              rsp_err_q,   rsp_err_d;

  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    illegal_d   = illegal_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // Illegal opcodes are still issued; the ALU answers 0 for them.
          alu_op_d  = cmd_op;
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          illegal_d = !is_legal_op(4'(cmd_op));
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = ST_WAIT_Z;
      ST_WAIT_Z: state_d = ST_CAPT;
      ST_CAPT: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_out;
        rsp_zero_d  = alu_z;
        rsp_err_d   = illegal_q;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    if (rst) begin
      state_q     <= ST_IDLE;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      illegal_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      illegal_q   <= illegal_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE);
  assign alu_operation = alu_op_q;
  assign alu_operand1  = alu_a_q;
  assign alu_operand2  = alu_b_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_zero      = rsp_zero_q;
  assign rsp_err       = rsp_err_q;

`ifdef ALU_SEQ_SELFCHECK_EN
  logic [DWIDTH-1:0] ref_result;
  logic [DWIDTH-1:0] exp_q, exp_d;
  logic              fail_q, fail_d;

  alu_ref_model #(.DWIDTH(DWIDTH), .OPW(OPW)) u_ref (
    .op     (alu_op_q),
    .a      (alu_a_q),
    .b      (alu_b_q),
    .result (ref_result)
  );

  always_comb begin
    exp_d  = exp_q;
    fail_d = fail_q;
    // Expected value is taken at E1, when the ALU samples the same inputs.
    if (state_q == ST_EXEC) exp_d = ref_result;
    if (state_q == ST_CAPT &&
        ((alu_out != exp_q) || (alu_z != (exp_q == '0)))) fail_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q  <= '0;
      fail_q <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      fail_q <= fail_d;
    end
  end

  assign selfcheck_fail = fail_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Drives alu_cmd_sequencer against a behavioural registered ALU and checks
// handshakes, latency, operand stability, responses and reset behaviour
// against expected values computed from the opcode table.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [3:0]    alu_operation;
  logic [DW-1:0] alu_operand1;
  logic [DW-1:0] alu_operand2;
  logic [DW-1:0] alu_out = '0;
  logic          alu_z = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_zero;
  logic          rsp_err;
`ifdef ALU_SEQ_SELFCHECK_EN
  logic          selfcheck_fail;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DWIDTH(DW), .OPW(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .alu_operation (alu_operation),
    .alu_operand1  (alu_operand1),
    .alu_operand2  (alu_operand2),
    .alu_out       (alu_out),
    .alu_z         (alu_z),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_zero      (rsp_zero),
    .rsp_err       (rsp_err)
`ifdef ALU_SEQ_SELFCHECK_EN
    ,
    .selfcheck_fail(selfcheck_fail)
`endif
  );

  // Opcode table written straight from the instruction set.
  function automatic logic [DW-1:0] alu_fn(input logic [3:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [31:0] r;
    case (op)
      4'd0: r = {16'h0, a};
      4'd1: r = {16'h0, a} + {16'h0, b};
      4'd2: r = {16'h0, a} - {16'h0, b};
      4'd3: r = {16'h0, a} * 2;
      4'd4: r = {16'h0, a} * 4;
      4'd5: r = {16'h0, a} / 16;
      4'd6: r = {16'h0, a} + 1;
      default: r = 32'h0;
    endcase
    return r[DW-1:0];
  endfunction

  // Registered ALU: out one edge after inputs are sampled, Z one edge later.
  always @(posedge clk) begin
    alu_out <= alu_fn(alu_operation, alu_operand1, alu_operand2);
    alu_z   <= (alu_out == '0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and follows it to the response handshake.
  // stall: cycles rsp_ready is held low once in DONE.
  // hold_valid: leave cmd_valid high after the accept.
  // waited: cycles spent waiting for cmd_ready before the accept.
  task automatic run_cmd(input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input int stall,
                         input bit hold_valid, output int waited);
    logic [DW-1:0] exp_data;
    logic [DW-1:0] held_data;
    exp_data  = alu_fn(op, a, b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = (stall == 0);
    waited    = 0;
    while (!cmd_ready && waited < 20) begin
      step();
      waited++;
    end
    if (!cmd_ready) begin
      check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    step();  // accept edge E0
    if (!hold_valid) cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      check("latency_rsp_valid", 32'(rsp_valid), 32'(cyc == 3));
      check("busy_cmd_ready", 32'(cmd_ready), 32'd0);
      check("alu_operation", 32'(alu_operation), 32'(op));
      check("alu_operand1", 32'(alu_operand1), 32'(a));
      check("alu_operand2", 32'(alu_operand2), 32'(b));
      if (cyc < 3) step();
    end
    check("rsp_data", 32'(rsp_data), 32'(exp_data));
    check("rsp_zero", 32'(rsp_zero), 32'(exp_data == '0));
    check("rsp_err", 32'(rsp_err), 32'(op > 4'd6));
    held_data = rsp_data;
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(rsp_data), 32'(held_data));
      check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      check("stall_alu_operand1", 32'(alu_operand1), 32'(a));
    end
    rsp_ready = 1'b1;
    step();  // response handshake edge
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_cmd_ready", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int w;
    logic [3:0] op;

    // Reset state.
    step();
    step();
    rst = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_operation", 32'(alu_operation), 32'd0);
    check("rst_alu_operand1", 32'(alu_operand1), 32'd0);
    check("rst_alu_operand2", 32'(alu_operand2), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);

    // Directed cases from the opcode table and wrap boundaries.
    run_cmd(4'b0001, 16'h0003, 16'h0004, 0, 1'b0, w);
    run_cmd(4'b0010, 16'h1234, 16'h1234, 0, 1'b0, w);
    run_cmd(4'b0001, 16'hFFFF, 16'h0001, 0, 1'b0, w);
    run_cmd(4'b0101, 16'h00F0, 16'hA5A5, 0, 1'b0, w);
    run_cmd(4'b0100, 16'h4001, 16'h0000, 0, 1'b0, w);
    run_cmd(4'b1010, 16'h5555, 16'h0000, 0, 1'b0, w);
    run_cmd(4'b0110, 16'hFFFF, 16'h0000, 0, 1'b0, w);

    // Backpressure with cmd_valid held; next command goes in right after.
    run_cmd(4'b0011, 16'h8421, 16'h0000, 5, 1'b1, w);
    run_cmd(4'b0000, 16'hBEEF, 16'h1111, 0, 1'b0, w);
    check("accept_after_handshake_wait", 32'(w), 32'd0);

    // Reset while in WAIT_Z discards the command.
    cmd_valid = 1'b1;
    cmd_op    = 4'b0001;
    cmd_a     = 16'h0100;
    cmd_b     = 16'h0200;
    rsp_ready = 1'b1;
    step();  // accept -> EXEC
    cmd_valid = 1'b0;
    step();  // -> WAIT_Z
    rst = 1'b1;
    step();
    check("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_alu_operation", 32'(alu_operation), 32'd0);
    check("midrst_alu_operand1", 32'(alu_operand1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("midrst_no_response", 32'(rsp_valid), 32'd0);
    end

    // Randomized commands, mostly legal opcodes.
    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(7, 15));
      else                           op = 4'($urandom_range(0, 6));
      run_cmd(op, 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)),
              1'($urandom_range(0, 1)), w);
    end

`ifdef ALU_SEQ_SELFCHECK_EN
    check("selfcheck_fail", 32'(selfcheck_fail), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
